// File: rtl/p_i_cache_ctrl_nway.sv
// ---------------------------------------------------------------------------
// p_i_cache_ctrl_nway
//   Control FSM for a pipelined, read-only, WAYS-way set-associative
//   instruction cache with tree pseudo-LRU replacement and a whole-cache
//   flush that clears one set per cycle while the pipeline is stalled.
//
// Parameters
//   WAYS      associativity (power of 2, 2..16)
//   SET_BITS  set-index width, SETS = 2**SET_BITS
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   mem_read_i          fetch request valid
//   mem_resp_o          fetch data valid this cycle
//   pmem_read_o         line-fill request to memory
//   pmem_resp_i         line-fill data valid
//   flush_req_i         pulse: invalidate the whole cache
//   flush_busy_o        high while a flush is in progress
//   pipe_hit_i          lookup-stage hit
//   pipe_way_hit_i      one-hot hit way
//   pipe_valid_i        valid bits of the indexed set
//   pipe_plru_i         PLRU bits of the indexed set (heap order, bit 0 = root)
//   way_load_o          one-hot: load tag / set valid / write data for a way
//   valid_datain_o      value written to the valid array
//   valid_clr_all_o     clear valid[set] in every way
//   flush_set_o         set index used while flushing
//   plru_load_o         write PLRU bits
//   plru_datain_o       new PLRU bits
//   addr_sel_o          0 = CPU address, 1 = miss address, 2 = flush_set
// ---------------------------------------------------------------------------
module p_i_cache_ctrl_nway #(
  parameter int WAYS     = 4,
  parameter int SET_BITS = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                mem_read_i,
  output logic                mem_resp_o,
  output logic                pmem_read_o,
  input  logic                pmem_resp_i,
  input  logic                flush_req_i,
  output logic                flush_busy_o,
  input  logic                pipe_hit_i,
  input  logic [WAYS-1:0]     pipe_way_hit_i,
  input  logic [WAYS-1:0]     pipe_valid_i,
  input  logic [WAYS-2:0]     pipe_plru_i,
  output logic [WAYS-1:0]     way_load_o,
  output logic                valid_datain_o,
  output logic                valid_clr_all_o,
  output logic [SET_BITS-1:0] flush_set_o,
  output logic                plru_load_o,
  output logic [WAYS-2:0]     plru_datain_o,
  output logic [1:0]          addr_sel_o
);

  localparam int LOG = $clog2(WAYS);

  typedef enum logic [1:0] {
    START = 2'd0,
    HIT   = 2'd1,
    MISS  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [SET_BITS-1:0] flush_cnt_q, flush_cnt_d;
  logic                flush_pend_q, flush_pend_d;
  // Set once the line has been written, so the re-lookup hit can be accepted
  // whether or not the memory keeps pmem_resp high for a second cycle.
  logic                fill_done_q, fill_done_d;
  logic                fill_we;
  logic [LOG-1:0]      victim;
  logic [LOG-1:0]      hit_idx;

  function automatic logic [LOG-1:0] onehot_to_idx(input logic [WAYS-1:0] oh);
    logic [LOG-1:0] r;
    r = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (oh[i]) r = r | LOG'(i);
    end
    return r;
  endfunction

  // Every node on the accessed way's path points away from it: the node bit
  // takes the value of the way-index bit chosen at that level.
  function automatic logic [WAYS-2:0] plru_update(input logic [WAYS-2:0] cur,
                                                  input logic [LOG-1:0]  w);
    logic [WAYS-2:0] r;
    int              n;
    r = cur;
    n = 0;
    for (int l = 0; l < LOG; l++) begin
      r[n] = w[LOG-1-l];
      n    = 2 * n + 1 + int'(w[LOG-1-l]);
    end
    return r;
  endfunction

  // Lowest invalid way wins; otherwise walk the tree (bit 0 -> upper half).
  function automatic logic [LOG-1:0] pick_victim(input logic [WAYS-1:0] valid,
                                                 input logic [WAYS-2:0] plru);
    logic [LOG-1:0] r;
    logic           go;
    int             n;
    r = '0;
    n = 0;
    for (int l = 0; l < LOG; l++) begin
      go         = ~plru[n];
      r[LOG-1-l] = go;
      n          = 2 * n + 1 + int'(go);
    end
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid[i]) r = LOG'(i);
    end
    return r;
  endfunction

  assign victim  = pick_victim(pipe_valid_i, pipe_plru_i);
  assign hit_idx = onehot_to_idx(pipe_way_hit_i);

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way_load
      assign way_load_o[gi] = fill_we & (victim == LOG'(gi));
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= START;
      flush_cnt_q  <= '0;
      flush_pend_q <= 1'b0;
      fill_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      flush_pend_q <= flush_pend_d;
      fill_done_q  <= fill_done_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    flush_cnt_d     = flush_cnt_q;
    flush_pend_d    = flush_pend_q;
    fill_done_d     = fill_done_q;
    fill_we         = 1'b0;
    mem_resp_o      = 1'b0;
    pmem_read_o     = 1'b0;
    flush_busy_o    = 1'b0;
    valid_datain_o  = 1'b0;
    valid_clr_all_o = 1'b0;
    flush_set_o     = '0;
    plru_load_o     = 1'b0;
    plru_datain_o   = '0;
    addr_sel_o      = 2'd0;

    unique case (state_q)
      START: begin
        flush_pend_d = 1'b0;
        fill_done_d  = 1'b0;
        if (flush_req_i)                   state_d = FLUSH;
        else if (mem_read_i && !pipe_hit_i) state_d = MISS;
        else if (mem_read_i)                state_d = HIT;
      end

      HIT: begin
        if (mem_read_i && pipe_hit_i) begin
          mem_resp_o    = 1'b1;
          plru_load_o   = 1'b1;
          plru_datain_o = plru_update(pipe_plru_i, hit_idx);
        end
        if (flush_req_i) begin
          state_d = FLUSH;
        end else if (mem_read_i && !pipe_hit_i) begin
          state_d     = MISS;
          fill_done_d = 1'b0;
        end
      end

      MISS: begin
        addr_sel_o  = 2'd1;
        pmem_read_o = !fill_done_q;
        if (flush_req_i) flush_pend_d = 1'b1;
        if (pmem_resp_i && !pipe_hit_i && !fill_done_q) begin
          fill_we        = 1'b1;
          valid_datain_o = 1'b1;
          fill_done_d    = 1'b1;
        end
        // Re-lookup hit after the fill: a pending flush runs before the
        // fetch is answered.
        if (pipe_hit_i && (pmem_resp_i || fill_done_q)) begin
          fill_done_d  = 1'b0;
          flush_pend_d = 1'b0;
          state_d      = (flush_pend_q || flush_req_i) ? FLUSH : HIT;
        end
      end

      FLUSH: begin
        addr_sel_o      = 2'd2;
        valid_clr_all_o = 1'b1;
        plru_load_o     = 1'b1;
        flush_busy_o    = 1'b1;
        flush_set_o     = flush_cnt_q;
        if (flush_cnt_q == {SET_BITS{1'b1}}) begin
          flush_cnt_d = '0;
          state_d     = START;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end

      default: state_d = START;
    endcase
  end

endmodule

// File: tb/tb_p_i_cache_ctrl_nway.sv
module tb_p_i_cache_ctrl_nway;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  // 4-way instance
  logic       mem_read = 0, pmem_resp = 0, flush_req = 0, pipe_hit = 0;
  logic [3:0] way_hit = 0, valid = 0;
  logic [2:0] plru = 0;
  logic       mem_resp, pmem_read, flush_busy, valid_datain, valid_clr_all, plru_load;
  logic [3:0] way_load;
  logic [2:0] flush_set, plru_datain;
  logic [1:0] addr_sel;
  // 8-way instance
  logic       mem_read8 = 0, pmem_resp8 = 0, pipe_hit8 = 0;
  logic [7:0] way_hit8 = 0, valid8 = 0;
  logic [6:0] plru8 = 0;
  logic       mem_resp8, pmem_read8, flush_busy8, valid_datain8, valid_clr_all8, plru_load8;
  logic [7:0] way_load8;
  logic [2:0] flush_set8;
  logic [6:0] plru_datain8;
  logic [1:0] addr_sel8;

  int errors = 0;
  int checks = 0;

  wire [17:0] outs0 = {mem_resp, pmem_read, flush_busy, way_load, valid_datain,
                       valid_clr_all, flush_set, plru_load, plru_datain, addr_sel};

  always #5 clk = ~clk;

  p_i_cache_ctrl_nway #(.WAYS(4), .SET_BITS(3)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .mem_read_i(mem_read), .mem_resp_o(mem_resp),
    .pmem_read_o(pmem_read), .pmem_resp_i(pmem_resp), .flush_req_i(flush_req),
    .flush_busy_o(flush_busy), .pipe_hit_i(pipe_hit), .pipe_way_hit_i(way_hit),
    .pipe_valid_i(valid), .pipe_plru_i(plru), .way_load_o(way_load),
    .valid_datain_o(valid_datain), .valid_clr_all_o(valid_clr_all),
    .flush_set_o(flush_set), .plru_load_o(plru_load), .plru_datain_o(plru_datain),
    .addr_sel_o(addr_sel));

  p_i_cache_ctrl_nway #(.WAYS(8), .SET_BITS(3)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .mem_read_i(mem_read8), .mem_resp_o(mem_resp8),
    .pmem_read_o(pmem_read8), .pmem_resp_i(pmem_resp8), .flush_req_i(1'b0),
    .flush_busy_o(flush_busy8), .pipe_hit_i(pipe_hit8), .pipe_way_hit_i(way_hit8),
    .pipe_valid_i(valid8), .pipe_plru_i(plru8), .way_load_o(way_load8),
    .valid_datain_o(valid_datain8), .valid_clr_all_o(valid_clr_all8),
    .flush_set_o(flush_set8), .plru_load_o(plru_load8), .plru_datain_o(plru_datain8),
    .addr_sel_o(addr_sel8));

  task automatic do_reset();
    @(negedge clk);
    rst = 1; mem_read = 0; pmem_resp = 0; flush_req = 0; pipe_hit = 0;
    way_hit = 0; valid = 0; plru = 0;
    mem_read8 = 0; pmem_resp8 = 0; pipe_hit8 = 0; way_hit8 = 0; valid8 = 0; plru8 = 0;
    repeat (2) @(negedge clk);
    #1 rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (outs0 !== 18'd0) begin
      errors++; $display("FAIL reset_outputs got=%h exp=0", outs0);
    end
    $display("reset: outputs=%h", outs0);
  endtask

  task automatic test_cold_miss();
    @(negedge clk);
    mem_read = 1; pipe_hit = 0; valid = 4'b0000; plru = 3'b100;
    #1 checks++;
    if ({pmem_read, mem_resp} !== 2'b00) begin
      errors++; $display("FAIL start_idle got=%b exp=00", {pmem_read, mem_resp});
    end
    @(negedge clk); #1 checks++;
    if ({pmem_read, addr_sel, way_load} !== {1'b1, 2'd1, 4'b0000}) begin
      errors++; $display("FAIL miss_request got=%b exp=1010000", {pmem_read, addr_sel, way_load});
    end
    @(negedge clk); pmem_resp = 1;
    #1 checks++;
    if ({way_load, valid_datain, mem_resp} !== {4'b0001, 1'b1, 1'b0}) begin
      errors++; $display("FAIL cold_fill got=%b exp=000110", {way_load, valid_datain, mem_resp});
    end
    @(negedge clk); pmem_resp = 0; pipe_hit = 1; way_hit = 4'b0001;
    #1 checks++;
    if ({pmem_read, mem_resp, way_load} !== 6'b0) begin
      errors++; $display("FAIL relookup_wait got=%b exp=000000", {pmem_read, mem_resp, way_load});
    end
    @(negedge clk); #1 checks++;
    if ({mem_resp, plru_load, plru_datain, addr_sel} !== {1'b1, 1'b1, 3'b100, 2'd0}) begin
      errors++; $display("FAIL cold_hit_resp got=%b exp=1110000", {mem_resp, plru_load, plru_datain, addr_sel});
    end
    $display("cold_miss: resp=%b plru_datain=%b", mem_resp, plru_datain);
  endtask

  // Starts in HIT with mem_read high; ends in HIT after the refill response.
  task automatic miss_fill(input logic [3:0] v, input logic [2:0] p,
                           input logic [3:0] exp_way, input string name);
    @(negedge clk); pipe_hit = 0; valid = v; plru = p; mem_read = 1;
    #1 checks++;
    if (mem_resp !== 1'b0) begin
      errors++; $display("FAIL %s_miss_resp got=%b exp=0", name, mem_resp);
    end
    @(negedge clk); pmem_resp = 1;
    #1 checks++;
    if ({way_load, pmem_read, mem_resp} !== {exp_way, 1'b1, 1'b0}) begin
      errors++; $display("FAIL %s_victim got=%b exp=%b10", name, {way_load, pmem_read, mem_resp}, exp_way);
    end
    @(negedge clk); pmem_resp = 0; pipe_hit = 1; way_hit = exp_way;
    @(negedge clk); #1 checks++;
    if (mem_resp !== 1'b1) begin
      errors++; $display("FAIL %s_refill_resp got=%b exp=1", name, mem_resp);
    end
    $display("%s: way_load victim checked, exp=%b", name, exp_way);
  endtask

  task automatic test_victim();
    miss_fill(4'b1111, 3'b000, 4'b1000, "victim_plru000");
    miss_fill(4'b1111, 3'b011, 4'b0001, "victim_plru011");
    miss_fill(4'b1011, 3'b111, 4'b0100, "victim_invalid2");
  endtask

  task automatic test_back_to_back();
    logic [1:0] ways [3] = '{2'd0, 2'd3, 2'd1};
    logic [2:0] expp [3] = '{3'b000, 3'b101, 3'b110};
    logic [2:0] p = 3'b000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); mem_read = 1; pipe_hit = 1; way_hit = 4'b0001 << ways[i]; plru = p;
      #1 checks++;
      if ({mem_resp, plru_load, plru_datain} !== {2'b11, expp[i]}) begin
        errors++; $display("FAIL b2b_hit%0d got=%b exp=11%b", i, {mem_resp, plru_load, plru_datain}, expp[i]);
      end
      $display("back_to_back: way=%0d resp=%b plru_datain=%b", ways[i], mem_resp, plru_datain);
      p = expp[i];
    end
  endtask

  task automatic test_flush();
    do_reset();
    @(negedge clk); flush_req = 1; mem_read = 1; pipe_hit = 1; way_hit = 4'b0001;
    #1 checks++;
    if ({flush_busy, mem_resp} !== 2'b00) begin
      errors++; $display("FAIL flush_start got=%b exp=00", {flush_busy, mem_resp});
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); flush_req = 0;
      #1 checks++;
      if ({flush_busy, valid_clr_all, plru_load, plru_datain, addr_sel, flush_set, mem_resp, pmem_read}
          !== {3'b111, 3'b000, 2'd2, 3'(i), 2'b00}) begin
        errors++; $display("FAIL flush_cycle%0d got=%b", i,
          {flush_busy, valid_clr_all, plru_load, plru_datain, addr_sel, flush_set, mem_resp, pmem_read});
      end
      $display("flush: cycle=%0d set=%0d busy=%b", i, flush_set, flush_busy);
    end
    @(negedge clk); #1 checks++;
    if ({flush_busy, valid_clr_all, mem_resp} !== 3'b000) begin
      errors++; $display("FAIL flush_end got=%b exp=000", {flush_busy, valid_clr_all, mem_resp});
    end
    @(negedge clk); #1 checks++;
    if (mem_resp !== 1'b1) begin
      errors++; $display("FAIL flush_resume got=%b exp=1", mem_resp);
    end
  endtask

  task automatic test_flush_during_miss();
    do_reset();
    @(negedge clk); mem_read = 1; pipe_hit = 0; valid = 4'b1111; plru = 3'b000;
    @(negedge clk); flush_req = 1;
    #1 checks++;
    if ({pmem_read, flush_busy} !== 2'b10) begin
      errors++; $display("FAIL fdm_miss got=%b exp=10", {pmem_read, flush_busy});
    end
    @(negedge clk); flush_req = 0; pmem_resp = 1;
    #1 checks++;
    if ({way_load, flush_busy} !== {4'b1000, 1'b0}) begin
      errors++; $display("FAIL fdm_fill got=%b exp=10000", {way_load, flush_busy});
    end
    @(negedge clk); pmem_resp = 0; pipe_hit = 1; way_hit = 4'b1000;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 checks++;
      if ({flush_busy, mem_resp, flush_set} !== {2'b10, 3'(i)}) begin
        errors++; $display("FAIL fdm_flush%0d got=%b", i, {flush_busy, mem_resp, flush_set});
      end
      @(negedge clk);
    end
    pipe_hit = 0;
    #1 checks++;
    if ({flush_busy, mem_resp} !== 2'b00) begin
      errors++; $display("FAIL fdm_start got=%b exp=00", {flush_busy, mem_resp});
    end
    @(negedge clk); #1 checks++;
    if ({pmem_read, addr_sel} !== {1'b1, 2'd1}) begin
      errors++; $display("FAIL fdm_remiss got=%b exp=101", {pmem_read, addr_sel});
    end
    $display("flush_during_miss: remiss pmem_read=%b", pmem_read);
    mem_read = 0;
  endtask

  task automatic test_rst_flush();
    do_reset();
    @(negedge clk); flush_req = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); flush_req = 0;
    end
    #1 checks++;
    if (flush_set !== 3'd4) begin
      errors++; $display("FAIL rstf_set4 got=%0d exp=4", flush_set);
    end
    rst = 1;
    @(negedge clk); #1 checks++;
    if (outs0 !== 18'd0) begin
      errors++; $display("FAIL rstf_outputs got=%h exp=0", outs0);
    end
    rst = 0;
    @(negedge clk); flush_req = 1;
    #1 checks++;
    if (outs0 !== 18'd0) begin
      errors++; $display("FAIL rstf_idle got=%h exp=0", outs0);
    end
    @(negedge clk); flush_req = 0;
    #1 checks++;
    if ({flush_busy, flush_set} !== {1'b1, 3'd0}) begin
      errors++; $display("FAIL rstf_counter got=%b exp=1000", {flush_busy, flush_set});
    end
    $display("rst_in_flush: restarted flush_set=%0d", flush_set);
    repeat (8) @(negedge clk);
  endtask

  task automatic test_ways8();
    do_reset();
    @(negedge clk); mem_read8 = 1; pipe_hit8 = 0; valid8 = 8'hFF; plru8 = 7'b0000000;
    @(negedge clk); pmem_resp8 = 1;
    #1 checks++;
    if (way_load8 !== 8'h80) begin
      errors++; $display("FAIL w8_victim7 got=%h exp=80", way_load8);
    end
    plru8 = 7'b0001011;
    #1 checks++;
    if (way_load8 !== 8'h01) begin
      errors++; $display("FAIL w8_victim0 got=%h exp=01", way_load8);
    end
    $display("ways8: way_load=%h", way_load8);
    pmem_resp8 = 0; mem_read8 = 0;
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_victim();
    test_back_to_back();
    test_flush();
    test_flush_during_miss();
    test_rst_flush();
    test_ways8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
